// File: rtl/pwm_period_counter_slave.sv
// Purpose : slave PWM time-base; free-runs in UP/DOWN/UP_DOWN and reloads a clamped phase on master sync.
// Latency : one edge from accepted sync to loaded count; o_period_next is the same-cycle preview.
// Backpressure: none; i_en=0 freezes count state, and syncs arriving while frozen are dropped.
//
// Ports:
//   i_clk, i_reset        clock; asynchronous active-high reset
//   i_en                  count enable (cnt, dir and sync register hold when low)
//   i_mode                00 OFF, 01 UP, 10 DOWN, 11 UP_DOWN
//   i_period              terminal count value
//   i_phase, i_phase_dir  count and UP_DOWN direction loaded on an accepted sync
//   i_sync_in, i_sync_in_en   incoming sync pulse and its accept gate
//   i_sync_out_en         gate for o_sync
//   o_period              counter register
//   o_period_next         value the counter takes on the next enabled edge
//   o_sync                high while the counter sits at i_period (daisy-chain sync)
//   o_sync_event          one-cycle pulse: a sync was accepted on the last edge
//   o_phase_err           one-cycle pulse: the accepted sync disagreed with free-run count
module pwm_period_counter_slave #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_en,
    input  logic [1:0]       i_mode,
    input  logic [WIDTH-1:0] i_period,
    input  logic [WIDTH-1:0] i_phase,
    input  logic             i_phase_dir,
    input  logic             i_sync_in,
    input  logic             i_sync_in_en,
    input  logic             i_sync_out_en,
    output logic [WIDTH-1:0] o_period,
    output logic [WIDTH-1:0] o_period_next,
    output logic             o_sync,
    output logic             o_sync_event,
    output logic             o_phase_err
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_UP      = 2'b01,
        MODE_DOWN    = 2'b10,
        MODE_UP_DOWN = 2'b11
    } mode_e;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // dir encoding: 0 counting up, 1 counting down (only meaningful in UP_DOWN)
    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             r_sync;

    logic [WIDTH-1:0] nat;
    logic             dir_nat;
    logic [WIDTH-1:0] ld;
    logic             accept;
    mode_e            mode;

    assign mode   = mode_e'(i_mode);
    assign accept = i_en & i_sync_in & i_sync_in_en & (mode != MODE_OFF);

    // A phase beyond the period would park the counter outside its range; clamp it.
    assign ld = (i_phase > i_period) ? i_period : i_phase;

    // Free-running next count, as if no sync were present.
    always_comb begin
        nat     = cnt;
        dir_nat = dir;
        unique case (mode)
            MODE_OFF: begin
                nat     = cnt;
                dir_nat = dir;
            end
            MODE_UP: begin
                // >= so a counter stranded above a freshly shrunk period wraps at once
                nat = (cnt >= i_period) ? '0 : cnt + ONE;
            end
            MODE_DOWN: begin
                // a stranded counter above the period simply keeps decrementing
                nat = (cnt == '0) ? i_period : cnt - ONE;
            end
            MODE_UP_DOWN: begin
                if (i_period == '0) begin
                    nat = '0;
                end else if (!dir) begin
                    if (cnt >= i_period) begin
                        nat     = cnt - ONE;
                        dir_nat = 1'b1;
                    end else begin
                        nat = cnt + ONE;
                    end
                end else begin
                    if (cnt == '0) begin
                        nat     = ONE;
                        dir_nat = 1'b0;
                    end else begin
                        nat = cnt - ONE;
                    end
                end
            end
            default: begin
                nat     = cnt;
                dir_nat = dir;
            end
        endcase
    end

    // Sync wins over any wrap or turn-around on the same edge.
    assign o_period_next = accept ? ld : nat;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt    <= '0;
            dir    <= 1'b0;
            r_sync <= 1'b0;
        end else if (i_en) begin
            cnt    <= o_period_next;
            dir    <= accept ? i_phase_dir : dir_nat;
            r_sync <= (o_period_next == i_period);
        end
    end

    // Status pulses are sampled every edge so they always clear after one cycle,
    // even while counting is disabled.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_sync_event <= 1'b0;
            o_phase_err  <= 1'b0;
        end else begin
            o_sync_event <= accept;
            o_phase_err  <= accept & (nat != ld);
        end
    end

    assign o_period = cnt;
    assign o_sync   = r_sync & i_sync_out_en;

endmodule

// File: tb/tb_pwm_period_counter_slave.sv
module tb_pwm_period_counter_slave;
    localparam int W = 16;

    logic         i_clk = 1'b0;
    logic         i_reset;
    logic         i_en;
    logic [1:0]   i_mode;
    logic [W-1:0] i_period;
    logic [W-1:0] i_phase;
    logic         i_phase_dir;
    logic         i_sync_in;
    logic         i_sync_in_en;
    logic         i_sync_out_en;
    logic [W-1:0] o_period;
    logic [W-1:0] o_period_next;
    logic         o_sync;
    logic         o_sync_event;
    logic         o_phase_err;

    int errors = 0;
    int checks = 0;

    pwm_period_counter_slave #(.WIDTH(W)) dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_en          (i_en),
        .i_mode        (i_mode),
        .i_period      (i_period),
        .i_phase       (i_phase),
        .i_phase_dir   (i_phase_dir),
        .i_sync_in     (i_sync_in),
        .i_sync_in_en  (i_sync_in_en),
        .i_sync_out_en (i_sync_out_en),
        .o_period      (o_period),
        .o_period_next (o_period_next),
        .o_sync        (o_sync),
        .o_sync_event  (o_sync_event),
        .o_phase_err   (o_phase_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic do_reset(input logic [1:0] mode, input int per, input int ph, input logic pdir);
        i_reset       = 1'b1;
        i_en          = 1'b1;
        i_mode        = mode;
        i_period      = W'(per);
        i_phase       = W'(ph);
        i_phase_dir   = pdir;
        i_sync_in     = 1'b0;
        i_sync_in_en  = 1'b1;
        i_sync_out_en = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    // Drive one clock with the given sync input, sample 1 time unit after the edge.
    task automatic step(input logic s);
        i_sync_in = s;
        @(posedge i_clk);
        #1;
        i_sync_in = 1'b0;
    endtask

    task automatic test_reset;
        i_reset = 1'b1; i_en = 1'b0; i_mode = 2'b00; i_period = W'(4); i_phase = '0;
        i_phase_dir = 1'b0; i_sync_in = 1'b0; i_sync_in_en = 1'b0; i_sync_out_en = 1'b1;
        #1;
        checks++; if (o_period !== W'(0)) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_period); end
        checks++; if (o_period_next !== W'(0)) begin errors++; $display("FAIL reset_next got=%0d exp=0", o_period_next); end
        checks++; if (o_sync !== 1'b0) begin errors++; $display("FAIL reset_sync got=%b exp=0", o_sync); end
        checks++; if (o_sync_event !== 1'b0) begin errors++; $display("FAIL reset_evt got=%b exp=0", o_sync_event); end
        checks++; if (o_phase_err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", o_phase_err); end
    endtask

    // UP, period 4, phase 0, master-style sync while master sits at 4: stays locked.
    task automatic test_up_lock;
        int exp_c[11] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
        bit syn[11]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        do_reset(2'b01, 4, 0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(syn[i]);
            checks++; if (o_period !== W'(exp_c[i])) begin errors++; $display("FAIL up_lock_cnt[%0d] got=%0d exp=%0d", i, o_period, exp_c[i]); end
            checks++; if (o_phase_err !== 1'b0) begin errors++; $display("FAIL up_lock_err[%0d] got=%b exp=0", i, o_phase_err); end
            checks++; if (o_sync_event !== syn[i]) begin errors++; $display("FAIL up_lock_evt[%0d] got=%b exp=%b", i, o_sync_event, syn[i]); end
            checks++; if (o_sync !== (exp_c[i] == 4)) begin errors++; $display("FAIL up_lock_sync[%0d] got=%b exp=%b", i, o_sync, exp_c[i] == 4); end
        end
    endtask

    // UP, period 4, phase 2: first sync misaligned, later syncs land where nat already equals 2.
    task automatic test_up_phase;
        int exp_c[11] = '{1, 2, 3, 4, 2, 3, 4, 0, 1, 2, 3};
        bit syn[11]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
        bit err[11]   = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        do_reset(2'b01, 4, 2, 1'b0);
        for (int i = 0; i < 11; i++) begin
            step(syn[i]);
            checks++; if (o_period !== W'(exp_c[i])) begin errors++; $display("FAIL up_phase_cnt[%0d] got=%0d exp=%0d", i, o_period, exp_c[i]); end
            checks++; if (o_phase_err !== err[i]) begin errors++; $display("FAIL up_phase_err[%0d] got=%b exp=%b", i, o_phase_err, err[i]); end
            checks++; if (o_sync !== (exp_c[i] == 4)) begin errors++; $display("FAIL up_phase_sync[%0d] got=%b exp=%b", i, o_sync, exp_c[i] == 4); end
        end
    endtask

    // Phase 9 above period 4 clamps to 4.
    task automatic test_clamp;
        do_reset(2'b01, 4, 9, 1'b0);
        i_sync_in = 1'b1;
        #1;
        checks++; if (o_period_next !== W'(4)) begin errors++; $display("FAIL clamp_next got=%0d exp=4", o_period_next); end
        step(1'b1);
        checks++; if (o_period !== W'(4)) begin errors++; $display("FAIL clamp_cnt got=%0d exp=4", o_period); end
        checks++; if (o_sync !== 1'b1) begin errors++; $display("FAIL clamp_sync got=%b exp=1", o_sync); end
        checks++; if (o_phase_err !== 1'b1) begin errors++; $display("FAIL clamp_err got=%b exp=1", o_phase_err); end
        step(1'b0);
        checks++; if (o_period !== W'(0)) begin errors++; $display("FAIL clamp_wrap got=%0d exp=0", o_period); end
        checks++; if (o_sync !== 1'b0) begin errors++; $display("FAIL clamp_sync_lo got=%b exp=0", o_sync); end
        checks++; if (o_sync_event !== 1'b0) begin errors++; $display("FAIL clamp_evt_lo got=%b exp=0", o_sync_event); end
    endtask

    // DOWN, period 3, phase 0.
    task automatic test_down;
        int exp_c[6] = '{0, 3, 2, 1, 0, 3};
        bit syn[6]   = '{1, 0, 0, 0, 0, 0};
        do_reset(2'b10, 3, 0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(syn[i]);
            checks++; if (o_period !== W'(exp_c[i])) begin errors++; $display("FAIL down_cnt[%0d] got=%0d exp=%0d", i, o_period, exp_c[i]); end
            checks++; if (o_sync !== (exp_c[i] == 3)) begin errors++; $display("FAIL down_sync[%0d] got=%b exp=%b", i, o_sync, exp_c[i] == 3); end
            checks++; if (o_phase_err !== syn[i]) begin errors++; $display("FAIL down_err[%0d] got=%b exp=%b", i, o_phase_err, syn[i]); end
        end
    endtask

    // UP_DOWN, period 3; sync at cnt=1 (dir up) loads 2 with dir down, nat also 2 -> no error.
    task automatic test_up_down;
        int exp_c[11] = '{1, 2, 3, 2, 1, 0, 1, 2, 1, 0, 1};
        bit syn[11]   = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
        do_reset(2'b11, 3, 2, 1'b1);
        for (int i = 0; i < 11; i++) begin
            step(syn[i]);
            checks++; if (o_period !== W'(exp_c[i])) begin errors++; $display("FAIL ud_cnt[%0d] got=%0d exp=%0d", i, o_period, exp_c[i]); end
            checks++; if (o_sync_event !== syn[i]) begin errors++; $display("FAIL ud_evt[%0d] got=%b exp=%b", i, o_sync_event, syn[i]); end
            checks++; if (o_phase_err !== 1'b0) begin errors++; $display("FAIL ud_err[%0d] got=%b exp=0", i, o_phase_err); end
        end
    endtask

    task automatic test_enable_gates;
        do_reset(2'b01, 4, 0, 1'b0);
        step(1'b0);
        step(1'b0);
        i_en = 1'b0;
        step(1'b1);
        checks++; if (o_period !== W'(2)) begin errors++; $display("FAIL en_hold_cnt got=%0d exp=2", o_period); end
        checks++; if (o_sync_event !== 1'b0) begin errors++; $display("FAIL en_hold_evt got=%b exp=0", o_sync_event); end
        step(1'b1);
        checks++; if (o_period !== W'(2)) begin errors++; $display("FAIL en_hold_cnt2 got=%0d exp=2", o_period); end
        i_en = 1'b1;
        step(1'b0);
        checks++; if (o_period !== W'(3)) begin errors++; $display("FAIL en_resume got=%0d exp=3", o_period); end
        i_sync_in_en = 1'b0;
        step(1'b1);
        checks++; if (o_period !== W'(4)) begin errors++; $display("FAIL sync_in_en_cnt got=%0d exp=4", o_period); end
        checks++; if (o_sync_event !== 1'b0) begin errors++; $display("FAIL sync_in_en_evt got=%b exp=0", o_sync_event); end
        checks++; if (o_sync !== 1'b1) begin errors++; $display("FAIL sync_out_on got=%b exp=1", o_sync); end
        i_sync_out_en = 1'b0;
        #1;
        checks++; if (o_sync !== 1'b0) begin errors++; $display("FAIL sync_out_gate got=%b exp=0", o_sync); end
        i_sync_out_en = 1'b1;
    endtask

    // Sync on consecutive cycles reloads every time.
    task automatic test_back_to_back;
        int exp_c[4] = '{1, 1, 1, 2};
        bit syn[4]   = '{1, 1, 1, 0};
        bit err[4]   = '{0, 1, 1, 0};
        do_reset(2'b01, 4, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(syn[i]);
            checks++; if (o_period !== W'(exp_c[i])) begin errors++; $display("FAIL b2b_cnt[%0d] got=%0d exp=%0d", i, o_period, exp_c[i]); end
            checks++; if (o_phase_err !== err[i]) begin errors++; $display("FAIL b2b_err[%0d] got=%b exp=%b", i, o_phase_err, err[i]); end
            checks++; if (o_sync_event !== syn[i]) begin errors++; $display("FAIL b2b_evt[%0d] got=%b exp=%b", i, o_sync_event, syn[i]); end
        end
    endtask

    // Period shrink below the count, then a mode change from the current count.
    task automatic test_shrink_mode;
        do_reset(2'b01, 4, 0, 1'b0);
        step(1'b0); step(1'b0); step(1'b0);
        i_period = W'(1);
        step(1'b0);
        checks++; if (o_period !== W'(0)) begin errors++; $display("FAIL shrink_wrap got=%0d exp=0", o_period); end
        step(1'b0);
        checks++; if (o_period !== W'(1)) begin errors++; $display("FAIL shrink_up got=%0d exp=1", o_period); end
        step(1'b0);
        checks++; if (o_period !== W'(0)) begin errors++; $display("FAIL shrink_wrap2 got=%0d exp=0", o_period); end
        i_mode = 2'b10; i_period = W'(4);
        step(1'b0);
        checks++; if (o_period !== W'(4)) begin errors++; $display("FAIL mode_down got=%0d exp=4", o_period); end
        step(1'b0);
        checks++; if (o_period !== W'(3)) begin errors++; $display("FAIL mode_down2 got=%0d exp=3", o_period); end
    endtask

    task automatic test_reset_mid;
        do_reset(2'b01, 4, 9, 1'b0);
        step(1'b1);
        checks++; if (o_sync_event !== 1'b1) begin errors++; $display("FAIL rmid_pre_evt got=%b exp=1", o_sync_event); end
        #2;
        i_reset = 1'b1;
        #1;
        checks++; if (o_period !== W'(0)) begin errors++; $display("FAIL rmid_cnt got=%0d exp=0", o_period); end
        checks++; if (o_sync !== 1'b0) begin errors++; $display("FAIL rmid_sync got=%b exp=0", o_sync); end
        checks++; if (o_sync_event !== 1'b0) begin errors++; $display("FAIL rmid_evt got=%b exp=0", o_sync_event); end
        checks++; if (o_phase_err !== 1'b0) begin errors++; $display("FAIL rmid_err got=%b exp=0", o_phase_err); end
    endtask

    initial begin
        test_reset;
        test_up_lock;
        test_up_phase;
        test_clamp;
        test_down;
        test_up_down;
        test_enable_gates;
        test_back_to_back;
        test_shrink_mode;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
